// File: rtl/c5_fc_layer.sv
// c5_fc_layer: fully-connected stage fed by the pooled C3S4 feature map.
// One MAC lane walks IN_LEN inputs per neuron (one word per cycle), then
// shifts, saturates, adds bias, applies ReLU and writes one word per neuron.
module c5_fc_layer #(
  parameter int IN_LEN    = 400,
  parameter int OUT_LEN   = 120,
  parameter int FRAC_BITS = 8,
  parameter int RD_BASE   = 0,
  parameter int WR_BASE   = 0,
  parameter int ACC_W     = 48
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        work_finished,
  output logic [31:0] rd_addr_out,
  input  logic [15:0] rd_data_in,
  output logic [31:0] w_addr_out,
  input  logic [15:0] w_data_in,
  output logic [15:0] bias_addr_out,
  input  logic [15:0] bias_data_in,
  output logic [31:0] wr_addr_out,
  output logic [15:0] wr_data_out,
  output logic        wr_out_en
);

  // Pipeline depth behind the issue stage: RAM read, then product register.
  localparam int STAGES = 1;

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_LO = -ACC_W'(32768);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_WRITE,
    S_FIN
  } state_t;

  state_t state_q, state_d;

  logic [15:0] i_q, n_q;
  logic [1:0]  dcnt_q;
  logic        last_i, last_n;
  logic        start_run, next_neuron, step_i, do_write, enter_fin, abort;

  logic [STAGES:0]          vld_pipe;
  logic signed [31:0]       prod_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  sh;
  logic [15:0]              s1, s2, relu;
  logic [16:0]              s2w;

  assign last_i = (i_q == 16'(IN_LEN - 1));
  assign last_n = (n_q == 16'(OUT_LEN - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and the one-cycle control strobes that drive the datapath.
  always_comb begin
    state_d     = state_q;
    start_run   = 1'b0;
    next_neuron = 1'b0;
    step_i      = 1'b0;
    do_write    = 1'b0;
    enter_fin   = 1'b0;
    abort       = 1'b0;
    if (state_q != S_IDLE && !en) begin
      // Dropping en anywhere in a run discards everything in flight.
      abort   = 1'b1;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en) begin
            start_run = 1'b1;
            state_d   = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (last_i) state_d = S_DRAIN;
          else        step_i  = 1'b1;
        end
        S_DRAIN: begin
          if (dcnt_q == 2'd2) begin
            do_write = 1'b1;
            state_d  = S_WRITE;
          end
        end
        S_WRITE: begin
          if (last_n) begin
            enter_fin = 1'b1;
            state_d   = S_FIN;
          end else begin
            next_neuron = 1'b1;
            state_d     = S_ISSUE;
          end
        end
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Input/neuron counters and the registered read addresses derived from them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q           <= '0;
      n_q           <= '0;
      rd_addr_out   <= '0;
      w_addr_out    <= '0;
      bias_addr_out <= '0;
    end else if (start_run) begin
      i_q           <= '0;
      n_q           <= '0;
      rd_addr_out   <= 32'(RD_BASE);
      w_addr_out    <= '0;
      bias_addr_out <= '0;
    end else if (next_neuron) begin
      // Weight address simply keeps counting: neuron n+1 starts at (n+1)*IN_LEN.
      i_q           <= '0;
      n_q           <= n_q + 16'd1;
      rd_addr_out   <= 32'(RD_BASE);
      w_addr_out    <= w_addr_out + 32'd1;
      bias_addr_out <= n_q + 16'd1;
    end else if (step_i) begin
      i_q         <= i_q + 16'd1;
      rd_addr_out <= rd_addr_out + 32'd1;
      w_addr_out  <= w_addr_out + 32'd1;
    end
  end

  // Drain counter: three cycles to flush the read and product stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               dcnt_q <= '0;
    else if (state_q == S_DRAIN && !abort)    dcnt_q <= dcnt_q + 2'd1;
    else                                      dcnt_q <= '0;
  end

  // Valid shift register tracking issue -> data -> product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     vld_pipe <= '0;
    else if (abort) vld_pipe <= '0;
    else            vld_pipe <= {vld_pipe[STAGES-1:0], (state_q == S_ISSUE)};
  end

  // MAC: register the signed product, then accumulate; clear at neuron start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      if (vld_pipe[0])
        prod_q <= $signed(rd_data_in) * $signed(w_data_in);
      if (start_run || next_neuron)
        acc_q <= '0;
      else if (vld_pipe[1])
        acc_q <= acc_q + ACC_W'(prod_q);
    end
  end

  // Result path: rescale, clamp, add bias with clamp, then ReLU.
  always_comb begin
    sh = acc_q >>> FRAC_BITS;
    if (sh > SAT_HI)      s1 = 16'h7fff;
    else if (sh < SAT_LO) s1 = 16'h8000;
    else                  s1 = sh[15:0];
    s2w = {s1[15], s1} + {bias_data_in[15], bias_data_in};
    if (s2w[16] != s2w[15]) s2 = s2w[16] ? 16'h8000 : 16'h7fff;
    else                    s2 = s2w[15:0];
    relu = s2[15] ? 16'h0000 : s2;
  end

  // Output write port and completion pulse; data/addr hold between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_data_out   <= '0;
      wr_addr_out   <= '0;
      wr_out_en     <= 1'b0;
      work_finished <= 1'b0;
    end else begin
      wr_out_en     <= do_write;
      work_finished <= enter_fin;
      if (do_write) begin
        wr_data_out <= relu;
        wr_addr_out <= 32'(WR_BASE) + {16'd0, n_q};
      end
    end
  end

endmodule

// File: tb/tb_c5_fc_layer.sv
// Bench for c5_fc_layer with a small geometry (4 inputs, 2 neurons).
// Synchronous ROM/RAM models feed the DUT; a monitor collects write strobes,
// completion pulses and address traces, which are compared with a table of
// constant expectations and with an arithmetic reference model.
module tb_c5_fc_layer;
  localparam int IN_LEN  = 4;
  localparam int OUT_LEN = 2;
  localparam int FRAC    = 8;
  localparam int RD_BASE = 0;
  localparam int WR_BASE = 0;
  localparam int PER     = IN_LEN + 4;
  localparam int NCYC    = OUT_LEN * PER + 8;

  logic        clk = 1'b0;
  logic        rst_n, en;
  logic        work_finished, wr_out_en;
  logic [31:0] rd_addr_out, w_addr_out, wr_addr_out;
  logic [15:0] rd_data_in, w_data_in, bias_addr_out, bias_data_in, wr_data_out;

  c5_fc_layer #(
    .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .FRAC_BITS(FRAC),
    .RD_BASE(RD_BASE), .WR_BASE(WR_BASE), .ACC_W(48)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .work_finished(work_finished),
    .rd_addr_out(rd_addr_out), .rd_data_in(rd_data_in),
    .w_addr_out(w_addr_out), .w_data_in(w_data_in),
    .bias_addr_out(bias_addr_out), .bias_data_in(bias_data_in),
    .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out), .wr_out_en(wr_out_en)
  );

  always #5 clk = ~clk;

  logic [15:0] fmem [IN_LEN];
  logic [15:0] wmem [IN_LEN*OUT_LEN];
  logic [15:0] bmem [OUT_LEN];
  logic [15:0] expd [OUT_LEN];

  function automatic logic [15:0] rd_f(input logic [31:0] a);
    int k = int'(a) - RD_BASE;
    if (k >= 0 && k < IN_LEN) return fmem[k];
    return 16'h0;
  endfunction

  function automatic logic [15:0] rd_w(input logic [31:0] a);
    if (int'(a) < IN_LEN*OUT_LEN) return wmem[int'(a)];
    return 16'h0;
  endfunction

  function automatic logic [15:0] rd_b(input logic [15:0] a);
    if (int'(a) < OUT_LEN) return bmem[int'(a)];
    return 16'h0;
  endfunction

  // Synchronous memories: data valid one cycle after the address.
  always @(posedge clk) begin
    rd_data_in   <= rd_f(rd_addr_out);
    w_data_in    <= rd_w(w_addr_out);
    bias_data_in <= rd_b(bias_addr_out);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: Q-format dot product, clamp, bias add, clamp, ReLU.
  function automatic logic [15:0] model(input int n);
    longint sum = 0;
    longint s1, s2;
    for (int i = 0; i < IN_LEN; i++)
      sum += longint'(signed'(fmem[i])) * longint'(signed'(wmem[n*IN_LEN + i]));
    s1 = sum >>> FRAC;
    if (s1 > 32767) s1 = 32767;
    if (s1 < -32768) s1 = -32768;
    s2 = s1 + longint'(signed'(bmem[n]));
    if (s2 > 32767) s2 = 32767;
    if (s2 < -32768) s2 = -32768;
    if (s2 < 0) return 16'h0;
    return 16'(s2);
  endfunction

  typedef struct {
    int          c;
    logic [31:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t wq[$];
  int  fq[$];
  int  addr_err;

  // Start a run (en seen at edge 0) and monitor NCYC cycles; cycle c is the
  // interval after edge c-1. Optionally drop en or pulse reset at a cycle.
  task automatic run_collect(input int abort_c, input int rst_c);
    int t0, c, p, nn;
    wq.delete();
    fq.delete();
    addr_err = 0;
    @(negedge clk);
    en = 1'b1;
    t0 = cyc;
    for (int k = 0; k < NCYC; k++) begin
      @(negedge clk);
      c = cyc - t0;
      if (wr_out_en) wq.push_back('{c, wr_addr_out, wr_data_out});
      if (work_finished) begin
        fq.push_back(c);
        en = 1'b0;
      end
      if (abort_c < 0 && rst_c < 0 && c >= 1 && c <= OUT_LEN*PER) begin
        p  = (c - 1) % PER;
        nn = (c - 1) / PER;
        if (p < IN_LEN && (int'(rd_addr_out) != RD_BASE + p ||
                           int'(w_addr_out) != nn*IN_LEN + p)) addr_err++;
        if (p < IN_LEN + 3 && int'(bias_addr_out) != nn) addr_err++;
      end
      if (c == abort_c) en = 1'b0;
      if (c == rst_c) begin
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        chk("async_reset_outputs",
            {work_finished, wr_out_en, rd_addr_out, w_addr_out, bias_addr_out,
             wr_addr_out, wr_data_out} == '0, 1);
      end
      if (rst_c >= 0 && c == rst_c + 1) rst_n = 1'b1;
    end
    en = 1'b0;
  endtask

  task automatic check_run(input string tag);
    chk({tag, "_nwrites"}, wq.size(), OUT_LEN);
    for (int n = 0; n < OUT_LEN && n < wq.size(); n++) begin
      chk($sformatf("%s_wr%0d_cycle", tag, n), wq[n].c, (n + 1) * PER);
      chk($sformatf("%s_wr%0d_addr", tag, n), wq[n].a, WR_BASE + n);
      chk($sformatf("%s_wr%0d_data", tag, n), wq[n].d, expd[n]);
    end
    chk({tag, "_nfinished"}, fq.size(), 1);
    if (fq.size() > 0) chk({tag, "_finished_cycle"}, fq[0], OUT_LEN * PER + 1);
    chk({tag, "_addr_trace_errs"}, addr_err, 0);
  endtask

  task automatic fill(input logic [15:0] d, input logic [15:0] w, input logic [15:0] b);
    for (int i = 0; i < IN_LEN; i++) fmem[i] = d;
    for (int i = 0; i < IN_LEN*OUT_LEN; i++) wmem[i] = w;
    for (int i = 0; i < OUT_LEN; i++) bmem[i] = b;
  endtask

  typedef struct {
    logic [15:0] d, w, b, exp;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{16'h0100, 16'h0100, 16'h0000, 16'h0400};  // 1.0*1.0*4
    tbl[1] = '{16'h0100, 16'hFF00, 16'h0080, 16'h0000};  // -4.0+0.5 -> ReLU
    tbl[2] = '{16'h7FFF, 16'h7FFF, 16'h0100, 16'h7FFF};  // both clamps
    tbl[3] = '{16'h0200, 16'h0080, 16'h0010, 16'h0410};  // 2.0*0.5*4+bias

    rst_n = 1'b0;
    en    = 1'b0;
    fill(16'h0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    chk("reset_wr_out_en", wr_out_en, 0);
    chk("reset_work_finished", work_finished, 0);
    chk("reset_wr_data", wr_data_out, 0);
    chk("reset_addrs", {rd_addr_out, w_addr_out, bias_addr_out, wr_addr_out}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      fill(tbl[v].d, tbl[v].w, tbl[v].b);
      for (int n = 0; n < OUT_LEN; n++) expd[n] = tbl[v].exp;
      run_collect(-1, -1);
      check_run($sformatf("vec%0d", v));
    end

    // Randomized runs checked against the reference model.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < IN_LEN; i++)
        fmem[i] = (r < 3) ? 16'($urandom_range(0, 2047) - 1024) : 16'($urandom);
      for (int i = 0; i < IN_LEN*OUT_LEN; i++)
        wmem[i] = (r < 3) ? 16'($urandom_range(0, 2047) - 1024) : 16'($urandom);
      for (int i = 0; i < OUT_LEN; i++)
        bmem[i] = 16'($urandom_range(0, 4095) - 2048);
      for (int n = 0; n < OUT_LEN; n++) expd[n] = model(n);
      run_collect(-1, -1);
      check_run($sformatf("rnd%0d", r));
    end

    // Abort mid-drain: nothing written, no completion.
    fill(tbl[0].d, tbl[0].w, tbl[0].b);
    for (int n = 0; n < OUT_LEN; n++) expd[n] = tbl[0].exp;
    run_collect(6, -1);
    chk("abort6_nwrites", wq.size(), 0);
    chk("abort6_nfinished", fq.size(), 0);

    // Abort in the last drain cycle: the write registered there is dropped.
    run_collect(7, -1);
    chk("abort7_nwrites", wq.size(), 0);
    chk("abort7_nfinished", fq.size(), 0);

    run_collect(-1, -1);
    check_run("after_abort");

    // Reset during drain of neuron 1: only neuron 0 was written.
    run_collect(-1, PER + 6);
    chk("rst_nwrites", wq.size(), 1);
    if (wq.size() > 0) chk("rst_wr0_cycle", wq[0].c, PER);
    chk("rst_nfinished", fq.size(), 0);

    run_collect(-1, -1);
    check_run("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
